// File: rtl/mem_pkg.sv
// mem_pkg: shared limits, read-pipeline tag type and parameter legality check for arb_memory
package mem_pkg;
  localparam int MAX_CH = 8;
  localparam int MAX_RD_LAT = 4;
  localparam int CH_W = $clog2(MAX_CH);
  // Read-pipeline entry: the data word travels in a parallel WIDTH-wide stage register
  typedef struct packed {
    logic v;
    logic [CH_W-1:0] ch;
    logic e;
  } rd_tag_t;
  function automatic bit params_ok(input int width, input int depth, input int addr_width,
                                   input int num_ch, input int rd_lat);
    return width > 0 && width % 8 == 0 && depth >= 2 && addr_width >= $clog2(depth) &&
           num_ch >= 1 && num_ch <= MAX_CH && rd_lat >= 1 && rd_lat <= MAX_RD_LAT;
  endfunction
endpackage

// File: rtl/arb_memory_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant (clk, rst, req in; grant, win index out), pointer advances on grant
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic [PW-1:0]     win
);
  logic [PW-1:0] p;
  logic hit;
  function automatic logic [PW-1:0] wrap(input int s);
    return PW'(s >= NUM_CH ? s - NUM_CH : s);
  endfunction
  always_comb begin
    grant = '0;
    win = '0;
    hit = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!hit && req[wrap(int'(p) + k)]) begin
        hit = 1'b1;
        win = wrap(int'(p) + k);
      end
    end
    grant[win] = hit;
  end
  always_ff @(posedge clk) begin
    if (rst) p <= '0;
    else if (hit) p <= (win == PW'(NUM_CH - 1)) ? '0 : win + 1'b1;
  end
endmodule

// File: rtl/arb_memory.sv
// arb_memory: NUM_CH-requester round-robin shared memory with byte writes and RD_LAT read pipeline
// Ports: clk, rst (sync, active-high); per channel valid/ready handshake, wr_rd, addr, wdata, wstrb;
// per channel rdata/rvalid responses; err (address-error pulse) only when MEM_ADDR_CHECK_EN is defined.
module arb_memory
  import mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_CH = 2,
  parameter int RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          valid,
  output logic [NUM_CH-1:0]          ready,
  input  logic [NUM_CH-1:0]          wr_rd,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH*WIDTH-1:0]    wdata,
  input  logic [NUM_CH*WIDTH/8-1:0]  wstrb,
  output logic [NUM_CH*WIDTH-1:0]    rdata,
  output logic [NUM_CH-1:0]          rvalid
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic [NUM_CH-1:0]          err
`endif
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int NB = WIDTH / 8;
  if (!params_ok(WIDTH, DEPTH, ADDR_WIDTH, NUM_CH, RD_LAT)) begin : g_bad_params
    $error("arb_memory: illegal parameter combination");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] win, oc;
  logic acc, s_wr, in_range;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [WIDTH-1:0] s_wdata, s_dat, l_dat;
  logic [NB-1:0] s_strb;
  rd_tag_t s_tag, l_tag;
  rr_arbiter #(.NUM_CH(NUM_CH), .PW(PW)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(valid & {NUM_CH{!rst}}),
    .grant(ready),
    .win(win)
  );
  assign acc = |ready;
  assign s_wr = wr_rd[win];
  assign s_addr = addr[win*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_wdata = wdata[win*WIDTH +: WIDTH];
  assign s_strb = wstrb[win*NB +: NB];
  assign in_range = 32'(s_addr) < DEPTH;
  // Out-of-range reads may fetch junk here; the e flag forces the returned word to zero
  assign s_dat = mem[s_addr];
  assign s_tag = '{v: acc && !s_wr, ch: CH_W'(win), e: acc && !in_range};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (acc && s_wr && in_range) begin
      for (int k = 0; k < NB; k++) if (s_strb[k]) mem[s_addr][8*k +: 8] <= s_wdata[8*k +: 8];
    end
  end
  // The output registers form the last stage, so only RD_LAT-1 intermediate stages exist
  if (RD_LAT == 1) begin : g_direct
    assign l_tag = s_tag;
    assign l_dat = s_dat;
  end else begin : g_pipe
    rd_tag_t pt [RD_LAT-1];
    logic [WIDTH-1:0] pd [RD_LAT-1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < RD_LAT - 1; k++) pt[k] <= '0;
      end else begin
        pt[0] <= s_tag;
        for (int k = 1; k < RD_LAT - 1; k++) pt[k] <= pt[k-1];
      end
      pd[0] <= s_dat;
      for (int k = 1; k < RD_LAT - 1; k++) pd[k] <= pd[k-1];
    end
    assign l_tag = pt[RD_LAT-2];
    assign l_dat = pd[RD_LAT-2];
  end
  assign oc = PW'(l_tag.ch);
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= '0;
      rdata <= '0;
    end else begin
      rvalid <= '0;
      if (l_tag.v) begin
        rvalid[oc] <= 1'b1;
        rdata[oc*WIDTH +: WIDTH] <= l_tag.e ? '0 : l_dat;
      end
    end
  end
`ifdef MEM_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= '0;
    end else begin
      err <= '0;
      err[oc] <= l_tag.e;
    end
  end
`endif
endmodule

// File: tb/tb_arb_memory.sv
// tb_arb_memory: scoreboard bench for arb_memory (DEPTH=20, RD_LAT=3, two channels)
module tb_arb_memory;
  localparam int RL = 3;
  localparam int DP = 20;
  logic clk = 0, rst = 1;
  logic [1:0] valid = '0, ready, wr_rd = '0, rvalid;
  logic [9:0] addr = '0;
  logic [63:0] wdata = '0, rdata;
  logic [7:0] wstrb = '0;
`ifdef MEM_ADDR_CHECK_EN
  logic [1:0] err;
`endif
  arb_memory #(.WIDTH(32), .DEPTH(DP), .ADDR_WIDTH(5), .NUM_CH(2), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .wr_rd(wr_rd), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .rvalid(rvalid)
`ifdef MEM_ADDR_CHECK_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int due; int ch; bit rd; bit oor; logic [31:0] d;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] lane [2];
  logic [31:0] mm [DP];
  logic [1:0] eg, erv, eerr;
  int p_m, cnt, checks, errors, a;
  bit armed;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    cnt++;
    if (armed) begin
      erv = '0;
      eerr = '0;
      if (q.size() > 0 && q[0].due == cnt) begin
        e = q.pop_front();
        if (e.rd) begin
          erv[e.ch] = 1'b1;
          lane[e.ch] = e.d;
        end
        eerr[e.ch] = e.oor;
      end
      chk("rvalid", rvalid, erv);
      chk("rdata", rdata, {lane[1], lane[0]});
`ifdef MEM_ADDR_CHECK_EN
      chk("err", err, eerr);
`endif
      eg = '0;
      if (!rst)
        for (int k = 0; k < 2; k++) if (eg == 0 && valid[(p_m + k) % 2]) eg[(p_m + k) % 2] = 1'b1;
      chk("ready", ready, eg);
      if (rst) begin
        q.delete();
        lane[0] = '0;
        lane[1] = '0;
        p_m = 0;
        for (int i = 0; i < DP; i++) mm[i] = '0;
      end else begin
        for (int k = 0; k < 2; k++) if (eg[k]) begin
          a = int'(addr[k*5 +: 5]);
          if (wr_rd[k]) begin
            if (a < DP) begin
              for (int b = 0; b < 4; b++) if (wstrb[k*4 + b]) mm[a][8*b +: 8] = wdata[k*32 + 8*b +: 8];
            end else q.push_back('{cnt + RL, k, 1'b0, 1'b1, 32'h0});
          end else q.push_back('{cnt + RL, k, 1'b1, a >= DP, a < DP ? mm[a] : 32'h0});
          p_m = (k + 1) % 2;
        end
      end
    end
  end
  task automatic go(input int ch, input bit w, input int ad, input logic [31:0] d, input logic [3:0] s);
    int t;
    wr_rd[ch] = w;
    addr[ch*5 +: 5] = 5'(ad);
    wdata[ch*32 +: 32] = d;
    wstrb[ch*4 +: 4] = s;
    valid[ch] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ready[ch] && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("grant_wait", ready[ch], 1);
    @(posedge clk);
    #1 valid[ch] = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic settle();
    repeat (RL) @(posedge clk);
    #1;
  endtask
  initial begin
    lane[0] = '0;
    lane[1] = '0;
    repeat (2) @(posedge clk);
    #1 armed = 1'b1;
    do_reset();
    chk("reset_rvalid", rvalid, 0);
    chk("reset_rdata", rdata, 0);
    go(0, 1, 10, 32'h0000_0064, 4'hF);
    go(1, 0, 10, 0, 0);
    settle();
    chk("t1_rdata", rdata[63:32], 32'h0000_0064);
    go(0, 1, 3, 32'hAABBCCDD, 4'hF);
    go(0, 1, 3, 32'h11223344, 4'b0101);
    go(0, 0, 3, 0, 0);
    settle();
    chk("strb_rdata", rdata[31:0], 32'hAA22CC44);
    go(0, 1, 25, 32'hDEADBEEF, 4'hF);
    go(1, 0, 25, 0, 0);
    go(1, 0, 5, 0, 0);
    go(0, 0, 9, 0, 0);
    go(0, 0, 10, 0, 0);
    settle();
    chk("oor_rdata", rdata[63:32], 32'h0);
    chk("oor_keep", rdata[31:0], 32'h0000_0064);
    do_reset();
    wr_rd = 2'b01;
    addr = {5'd7, 5'd7};
    wdata = {32'h0, 32'hCAFEF00D};
    wstrb = 8'h0F;
    valid = 2'b11;
    @(negedge clk);
    chk("raw_first", ready, 2'b01);
    @(posedge clk);
    #1 valid[0] = 1'b0;
    @(negedge clk);
    chk("raw_second", ready, 2'b10);
    @(posedge clk);
    #1 valid[1] = 1'b0;
    settle();
    chk("raw_rdata", rdata[63:32], 32'hCAFEF00D);
    do_reset();
    go(0, 1, 1, 32'h0000_0111, 4'hF);
    go(1, 1, 2, 32'h0000_0222, 4'hF);
    wr_rd = 2'b00;
    addr = {5'd2, 5'd1};
    valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_order", ready, (i % 2) ? 2'b10 : 2'b01);
      @(posedge clk);
      #1;
    end
    valid = 2'b00;
    settle();
    chk("rr_rdata", rdata, {32'h0000_0222, 32'h0000_0111});
    go(0, 1, 12, 32'h5A5A5A5A, 4'hF);
    go(0, 0, 12, 0, 0);
    do_reset();
    repeat (6) @(posedge clk);
    #1 chk("flush_rvalid", rvalid, 0);
    go(0, 0, 12, 0, 0);
    settle();
    chk("flush_rdata", rdata[31:0], 32'h0);
    for (int i = 0; i < 24; i++)
      go($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 22), $urandom, 4'($urandom_range(0, 15)));
    repeat (RL + 3) @(posedge clk);
    #1 chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
